// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for multicycle_control: datapath status and
// handshakes in, control strobes and debug state out.
interface multicycle_control_if #(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 4
);
  logic [OP_W-1:0]       op;
  logic                  zero;
  logic                  if_ready;
  logic                  mem_ready;
  logic                  if_req;
  logic                  ir_write;
  logic                  pc_write;
  logic [2:0]            pc_src;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  alu_src;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_byte;
  logic                  mem_reg;
  logic                  reg_write;
  logic                  tlb_write;
  logic                  illegal_op;
  logic [2:0]            state;

  modport master (
    input  op, zero, if_ready, mem_ready,
    output if_req, ir_write, pc_write, pc_src, alu_ctrl, alu_src,
           mem_read, mem_write, mem_byte, mem_reg, reg_write,
           tlb_write, illegal_op, state
  );

  modport slave (
    output op, zero, if_ready, mem_ready,
    input  if_req, ir_write, pc_write, pc_src, alu_ctrl, alu_src,
           mem_read, mem_write, mem_byte, mem_reg, reg_write,
           tlb_write, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing with
// ready handshakes. Define CTRL_MUL_EN to make MUL legal with a MUL_LAT-cycle EXEC.
module multicycle_control #(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 4,
  parameter int MUL_LAT    = 4
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  if (OP_W < 6) begin : g_op_w_check
    $error("multicycle_control: OP_W must be at least 6");
  end
  if (MUL_LAT < 1) begin : g_mul_lat_check
    $error("multicycle_control: MUL_LAT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_MUL, C_LOAD, C_STORE, C_MOV, C_BEQ,
    C_JUMP, C_IRET, C_TLBW, C_ILLEGAL
  } op_class_e;

  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LBD = OP_W'(10);
  localparam logic [OP_W-1:0] OP_STB = OP_W'(12);

  function automatic op_class_e classify(input logic [OP_W-1:0] o);
    case (o)
      OP_W'(0), OP_W'(1), OP_W'(3), OP_W'(4): return C_RTYPE;
`ifdef CTRL_MUL_EN
      OP_W'(2):                               return C_MUL;
`endif
      OP_W'(10), OP_W'(11):                   return C_LOAD;
      OP_W'(12), OP_W'(13):                   return C_STORE;
      OP_W'(14):                              return C_MOV;
      OP_W'(30):                              return C_BEQ;
      OP_W'(31):                              return C_JUMP;
      OP_W'(32):                              return C_TLBW;
      OP_W'(33):                              return C_IRET;
      default:                                return C_ILLEGAL;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  op_class_e       cls;
  logic            mul_done;

  // DECODE acts on the live opcode; every later state uses the latched copy.
  assign cls = classify((state_q == S_DECODE) ? bus.op : op_q);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.op;
    end
  end

`ifdef CTRL_MUL_EN
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_DECODE && cls == C_MUL) begin
      cnt_q <= CNT_W'(MUL_LAT - 1);
    end else if (state_q == S_EXEC && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign mul_done = (cnt_q == '0);
`else
  assign mul_done = 1'b1;
`endif

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.if_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          C_JUMP, C_IRET, C_TLBW: state_d = S_FETCH;
          C_ILLEGAL:              state_d = S_TRAP;
          default:                state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BEQ:           state_d = S_FETCH;
          C_MUL:           if (mul_done) state_d = S_WB;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM:    if (bus.mem_ready) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.if_req     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 3'd0;
    bus.alu_ctrl   = '0;
    bus.alu_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_byte   = 1'b0;
    bus.mem_reg    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.tlb_write  = 1'b0;
    bus.illegal_op = 1'b0;
    bus.state      = rst ? 3'd0 : state_q;
    // Reset gates outputs combinationally so a pending access drops the same cycle.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.if_req = 1'b1;
          if (bus.if_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          case (cls)
            C_JUMP:  begin bus.pc_write = 1'b1; bus.pc_src = 3'd2; end
            C_IRET:  begin bus.pc_write = 1'b1; bus.pc_src = 3'd3; end
            C_TLBW:  bus.tlb_write = 1'b1;
            default: ;
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_RTYPE: begin
              case (op_q)
                OP_SUB:  bus.alu_ctrl = ALU_CTRL_W'(1);
                OP_AND:  bus.alu_ctrl = ALU_CTRL_W'(3);
                OP_OR:   bus.alu_ctrl = ALU_CTRL_W'(4);
                default: bus.alu_ctrl = ALU_CTRL_W'(0);
              endcase
            end
            C_MUL:                  bus.alu_ctrl = ALU_CTRL_W'(2);
            C_LOAD, C_STORE, C_MOV: bus.alu_src = 1'b1;
            C_BEQ: begin
              bus.alu_ctrl = ALU_CTRL_W'(1);
              if (bus.zero) begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 3'd1;
              end
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_read  = (cls == C_LOAD);
          bus.mem_write = (cls == C_STORE);
          bus.mem_byte  = (op_q == OP_LBD) || (op_q == OP_STB);
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.mem_reg   = (cls == C_LOAD);
        end
        S_TRAP: begin
          bus.illegal_op = 1'b1;
          bus.pc_write   = 1'b1;
          bus.pc_src     = 3'd4;
        end
        default: ;
      endcase
    end
  end

endmodule
